// File: rtl/plic_lite_ctrl_if.sv
// Register port between the PBUS bridge and the interrupt controller.
// Read data is returned the cycle after the read strobe.
interface plic_lite_ctrl_if;
  logic        reg_we_i;
  logic        reg_re_i;
  logic [9:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;

  modport master (
    output reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
    input  reg_rdata_o
  );

  modport slave (
    input  reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
    output reg_rdata_o
  );
endinterface

// File: rtl/plic_lite_ctrl.sv
// Single-target platform interrupt controller: level gateways, pending and
// in-flight tracking, priority/threshold arbitration and claim/complete.
module plic_lite_ctrl #(
  parameter int NUM_SRC    = 32,
  parameter int PRIO_WIDTH = 3
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic [NUM_SRC-1:0] intr_src_i,
  plic_lite_ctrl_if.slave    bus,
  output logic               irq_o,
  output logic [4:0]         claim_id_o
);

  localparam logic [7:0] W_PEND  = 8'h20;
  localparam logic [7:0] W_EN    = 8'h40;
  localparam logic [7:0] W_THR   = 8'h60;
  localparam logic [7:0] W_CLAIM = 8'h61;
  localparam logic [NUM_SRC-1:0] ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

  logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
  logic [NUM_SRC-1:0]    enable_q;
  logic [NUM_SRC-1:0]    pending_q;
  logic [NUM_SRC-1:0]    in_flight_q;
  logic [PRIO_WIDTH-1:0] thresh_q;
  logic [31:0]           rdata_q;

  logic [7:0]            word;
  logic                  wr_en;
  logic                  rd_en;
  logic                  claim_rd;
  logic                  complete_wr;
  logic                  prio_word;
  logic [NUM_SRC-1:0]    claim_mask;
  logic [NUM_SRC-1:0]    complete_mask;
  logic [NUM_SRC-1:0]    gate_set;
  logic [NUM_SRC-1:0]    eligible;
  logic [4:0]            win_id;
  logic [PRIO_WIDTH-1:0] win_prio;
  logic [31:0]           rd_mux;
  logic                  unused_bits;

  assign word        = bus.reg_addr_i[9:2];
  assign wr_en       = bus.reg_we_i;
  // A simultaneous write takes precedence; the read then has no side effect.
  assign rd_en       = bus.reg_re_i & ~bus.reg_we_i;
  assign prio_word   = (word < 8'(NUM_SRC));
  assign claim_rd    = rd_en && (word == W_CLAIM) && (claim_id_o != 5'd0);
  assign complete_wr = wr_en && (word == W_CLAIM);

  assign claim_mask    = claim_rd    ? (ONE << claim_id_o)              : '0;
  assign complete_mask = complete_wr ? (ONE << bus.reg_wdata_i[4:0])   : '0;
  assign gate_set      = intr_src_i & ~pending_q & ~in_flight_q & ~ONE;
  // The line being claimed this cycle is excluded so the next winner is ready
  // on the same edge that returns the claimed ID.
  assign eligible      = pending_q & ~claim_mask & enable_q;

  always_comb begin
    win_id   = 5'd0;
    win_prio = '0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (eligible[i] && (prio_q[i] > thresh_q) && (prio_q[i] > win_prio)) begin
        win_id   = 5'(i);
        win_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (prio_word) begin
      rd_mux = 32'(prio_q[word[4:0]]);
    end else begin
      case (word)
        W_PEND:  rd_mux = 32'(pending_q);
        W_EN:    rd_mux = 32'(enable_q);
        W_THR:   rd_mux = 32'(thresh_q);
        W_CLAIM: rd_mux = 32'(claim_id_o);
        default: rd_mux = '0;
      endcase
    end
  end

  // Register stage: configuration, gateway state, registered winner and read data
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
      enable_q    <= '0;
      thresh_q    <= '0;
      pending_q   <= '0;
      in_flight_q <= '0;
      claim_id_o  <= 5'd0;
      irq_o       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (wr_en) begin
        if (prio_word && (word != 8'd0)) prio_q[word[4:0]] <= bus.reg_wdata_i[PRIO_WIDTH-1:0];
        if (word == W_EN)  enable_q <= bus.reg_wdata_i[NUM_SRC-1:0] & ~ONE;
        if (word == W_THR) thresh_q <= bus.reg_wdata_i[PRIO_WIDTH-1:0];
      end
      pending_q   <= (pending_q | gate_set) & ~claim_mask;
      in_flight_q <= (in_flight_q & ~complete_mask) | claim_mask;
      claim_id_o  <= win_id;
      irq_o       <= (win_id != 5'd0);
      rdata_q     <= rd_en ? rd_mux : '0;
    end
  end

  assign bus.reg_rdata_o = rdata_q;
  assign unused_bits     = ^{bus.reg_addr_i[1:0], intr_src_i[0], bus.reg_wdata_i};

endmodule

// File: doc/plic_lite_ctrl.md
Name: plic_lite_ctrl

Overview:
Single-target platform interrupt controller that arbitrates the 32 statically mapped platform interrupt lines and drives the core external interrupt (CORE_EXT_INTERRUPT, mcause 11). Line 0 is reserved. Lines 1-4 carry GPIO In, TIM0, TIM1 and UART from the PBUS. The block performs level gateways, pending tracking, priority and threshold arbitration, and claim/complete sequencing. It sits on the PBUS behind a simple register port; the AXI-Lite-to-register bridge is external.

Parameters:
NUM_SRC, 32, number of interrupt lines including reserved line 0; legal range 2..32.
PRIO_WIDTH, 3, priority field width; priority 0 means never interrupt.

Ports:
clock_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
intr_src_i  in  NUM_SRC  level-sensitive sources, already synchronous to clock_i; bit 0 ignored
reg_we_i  in  1  register write strobe, single cycle
reg_re_i  in  1  register read strobe, single cycle
reg_addr_i  in  10  byte address, word aligned; bits [1:0] ignored
reg_wdata_i  in  32  write data
reg_rdata_o  out  32  read data, valid the cycle after reg_re_i
irq_o  out  1  external interrupt request to the core
claim_id_o  out  5  current arbitration winner, for debug

Behaviour:
- Reset (asynchronous, reset_ni=0): all priorities, enable, threshold, pending and in_flight are cleared; irq_o=0, claim_id_o=0, reg_rdata_o=0.
- Register map:
  - 0x000+4*i: priority[i], RW, bits [PRIO_WIDTH-1:0]. Priority of line 0 is hardwired to 0.
  - 0x080: pending, RO. Writes are ignored.
  - 0x100: enable, RW. Bit 0 is hardwired to 0.
  - 0x180: threshold, RW.
  - 0x184: claim/complete. A read performs a claim; a write performs a complete.
  - Unmapped addresses read 0; writes to them are ignored. Bits above NUM_SRC or PRIO_WIDTH read 0.
- Gateway, per line i≥1:
  - pending[i] sets at the next edge when intr_src_i[i]=1, pending[i]=0 and in_flight[i]=0.
  - Source deassertion does not clear pending.
  - While in_flight[i]=1, no new pending is generated for line i.
- Arbitration, combinational then registered:
  - Eligible: pending & enable & (priority > threshold).
  - Winner: the eligible line with the highest priority; ties go to the lowest ID.
  - claim_id_o is the registered winner (0 if none); irq_o = (claim_id_o != 0), also registered.
  - Latency: intr_src_i rising at edge N gives pending=1 after N and irq_o=1 after N+1.
- Claim, read of 0x184 at cycle C:
  - reg_rdata_o at C+1 is claim_id_o as sampled at C.
  - If the ID is nonzero, pending[id] clears and in_flight[id] sets at the C edge.
  - The arbiter re-evaluates; irq_o drops at C+1 if no other line is eligible.
  - A claim with ID 0 has no side effects.
- Complete, write of 0x184 with wdata[4:0]=id:
  - If in_flight[id]=1, it clears at the write edge. Otherwise the write is ignored.
  - An ID ≥ NUM_SRC is ignored.
- Simultaneous events:
  - Claim and source still high in the same cycle: in_flight wins, so no re-pend.
  - Complete and source high in the same cycle: in_flight clears at edge N and pending sets at N+1.
  - reg_we_i and reg_re_i both asserted: the write executes; the read returns 0 with no claim side effect.
  - Changing enable, priority or threshold takes effect on irq_o after one edge. Disabling a line leaves its pending bit set.
- Multiple lines may be in flight at once (nested claims are allowed).
- Reset asserted mid-claim: all state clears immediately and irq_o=0 asynchronously.

Test Plan:
1. Reset, then prio[4]=1, enable=0x10, threshold=0, pulse intr_src_i[4]=1 -> pending=0x10 after 1 edge, irq_o=1 after 2 edges, claim read returns 4, irq_o=0 next cycle, pending=0.
2. Lines 2 and 3 both prio=5, line 1 prio=6, all enabled and pending -> claims return 1, 2, 3 in order; a fourth claim returns 0.
3. threshold=5, line 2 prio=5 pending and enabled -> irq_o stays 0; threshold=4 -> irq_o=1 one edge later.
4. Line 4 claimed with intr_src_i[4] held high -> no re-pend; complete write of 4 -> pending[4]=1 one edge later, irq_o=1 the edge after.
5. Complete write of 3 while line 3 is not in flight, writes to 0x080 and to priority[0], and read of 0x1FC -> no state change; reads return 0.
6. reset_ni pulled low with lines pending and in flight -> irq_o=0 immediately; after release, all registers read 0.
